// File: rtl/ifu_bpu_pkg.sv
// Shared definitions for the fetch-stage branch predictor: opcode/encoding
// constants, counter states, instruction classes and the counter step helper.
package ifu_bpu_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // Bit n set means funct3 == n is a valid conditional branch (0,1,4,5,6,7).
    localparam logic [7:0] BR_FUNCT3_SET = 8'b1111_0011;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_BRANCH = 3'd1,
        CLS_JAL    = 3'd2,
        CLS_JALR   = 3'd3,
        CLS_SYSTEM = 3'd4
    } inst_class_t;

    function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        if (taken) begin
            if (c != CTR_ST) n = ctr_t'(c + 2'd1);
        end else begin
            if (c != CTR_SNT) n = ctr_t'(c - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/ifu_predecode.sv
// Combinational pre-decode of a fetched instruction: control-flow class,
// jump flag and sign-extended B/J immediates.
module ifu_predecode
    import ifu_bpu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     inst,
    output logic [2:0]      inst_class,
    output logic            jump,
    output logic [XLEN-1:0] b_imm,
    output logic [XLEN-1:0] j_imm
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    inst_class_t cls;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    always_comb begin
        cls = CLS_NONE;
        case (opcode)
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   if (funct3 == 3'd0) cls = CLS_JALR;
            OPC_BRANCH: if (BR_FUNCT3_SET[funct3]) cls = CLS_BRANCH;
            OPC_SYSTEM: if (inst == INST_ECALL || inst == INST_MRET || inst == INST_EBREAK)
                            cls = CLS_SYSTEM;
            default:    cls = CLS_NONE;
        endcase
    end

    assign inst_class = cls;
    assign jump       = (cls != CLS_NONE);
    assign b_imm      = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign j_imm      = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

endmodule

// File: rtl/ifu_bpu.sv
// Fetch-stage branch predictor: direct-mapped tagged table of 2-bit counters
// and targets, zero-cycle lookup, single-port update from execute.
module ifu_bpu
    import ifu_bpu_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_valid,
    input  logic [XLEN-1:0] io_pc,
    input  logic [31:0]     io_inst,
    output logic            io_jump,
    output logic            io_pred_taken,
    output logic [XLEN-1:0] io_pred_target,
    input  logic            io_upd_valid,
    input  logic [XLEN-1:0] io_upd_pc,
    input  logic            io_upd_taken,
    input  logic [XLEN-1:0] io_upd_target,
    input  logic            io_flush
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    ctr_t               ctr_q [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];

    logic [2:0]        cls_raw;
    inst_class_t       cls;
    logic [XLEN-1:0]   b_imm;
    logic [XLEN-1:0]   j_imm;
    logic [XLEN-1:0]   pc_plus4;

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;
    logic              lk_taken;

    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    ctr_t              upd_ctr;
    logic              unused_upd_pc;

    ifu_predecode #(.XLEN(XLEN)) u_predecode (
        .inst       (io_inst),
        .inst_class (cls_raw),
        .jump       (io_jump),
        .b_imm      (b_imm),
        .j_imm      (j_imm)
    );

    assign cls      = inst_class_t'(cls_raw);
    assign pc_plus4 = io_pc + XLEN'(4);

    assign lk_idx   = io_pc[IDX_W+1:2];
    assign lk_tag   = io_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && ctr_q[lk_idx][1];

    always_comb begin
        io_pred_taken  = 1'b0;
        io_pred_target = pc_plus4;
        if (io_valid) begin
            case (cls)
                CLS_JAL: begin
                    io_pred_taken  = 1'b1;
                    io_pred_target = io_pc + j_imm;
                end
                CLS_BRANCH: if (lk_taken) begin
                    io_pred_taken  = 1'b1;
                    io_pred_target = io_pc + b_imm;
                end
                CLS_JALR: if (lk_taken) begin
                    io_pred_taken  = 1'b1;
                    io_pred_target = tgt_q[lk_idx];
                end
                default: io_pred_taken = 1'b0;
            endcase
        end
    end

    assign upd_idx = io_upd_pc[IDX_W+1:2];
    assign upd_tag = io_upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_ctr = upd_hit ? ctr_update(ctr_q[upd_idx], io_upd_taken)
                             : (io_upd_taken ? CTR_WT : CTR_WNT);
    assign unused_upd_pc = ^{io_upd_pc[XLEN-1:IDX_W+TAG_W+2], io_upd_pc[1:0]};

    // Flush only drops valid bits; an update in the same cycle is discarded.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                ctr_q[i] <= CTR_WNT;
                tgt_q[i] <= '0;
            end
        end else if (io_flush) begin
            valid_q <= '0;
        end else if (io_upd_valid) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            ctr_q[upd_idx]   <= upd_ctr;
            if (!upd_hit || io_upd_taken) tgt_q[upd_idx] <= io_upd_target;
        end
    end

endmodule

// File: tb/tb_ifu_bpu.sv
// Self-checking bench for ifu_bpu: lookup expectations are queued with their
// stimulus and popped as each lookup is presented to the predictor.
module tb_ifu_bpu;

    localparam logic [31:0] I_BEQ_P8  = 32'h0000_0463;
    localparam logic [31:0] I_BEQ_M8  = 32'hfe00_0ce3;
    localparam logic [31:0] I_JAL_P16 = 32'h0100_006f;
    localparam logic [31:0] I_JAL_M4  = 32'hffdf_f06f;
    localparam logic [31:0] I_JALR    = 32'h0000_8067;
    localparam logic [31:0] I_ADDI    = 32'h0000_0013;
    localparam logic [31:0] I_MRET    = 32'h3020_0073;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_valid = 1'b0;
    logic [63:0] io_pc = '0;
    logic [31:0] io_inst = '0;
    logic        io_jump;
    logic        io_pred_taken;
    logic [63:0] io_pred_target;
    logic        io_upd_valid = 1'b0;
    logic [63:0] io_upd_pc = '0;
    logic        io_upd_taken = 1'b0;
    logic [63:0] io_upd_target = '0;
    logic        io_flush = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        valid;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        jump;
        logic        taken;
        logic [63:0] target;
    } item_t;

    item_t sb[$];

    always #5 clock = ~clock;

    ifu_bpu #(.XLEN(64), .ENTRIES(16), .TAG_W(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_valid       (io_valid),
        .io_pc          (io_pc),
        .io_inst        (io_inst),
        .io_jump        (io_jump),
        .io_pred_taken  (io_pred_taken),
        .io_pred_target (io_pred_target),
        .io_upd_valid   (io_upd_valid),
        .io_upd_pc      (io_upd_pc),
        .io_upd_taken   (io_upd_taken),
        .io_upd_target  (io_upd_target),
        .io_flush       (io_flush)
    );

    function automatic void push(input string name, input logic valid, input logic [63:0] pc,
                                 input logic [31:0] inst, input logic jump, input logic taken,
                                 input logic [63:0] target);
        item_t it;
        it.name = name; it.valid = valid; it.pc = pc; it.inst = inst;
        it.jump = jump; it.taken = taken; it.target = target;
        sb.push_back(it);
    endfunction

    task automatic do_update(input logic [63:0] pc, input logic taken, input logic [63:0] target);
        @(negedge clock);
        io_upd_valid = 1'b1; io_upd_pc = pc; io_upd_taken = taken; io_upd_target = target;
        @(negedge clock);
        io_upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        item_t it;
        push("rst_beq",     1, 64'h8000_0000, I_BEQ_P8,  1, 0, 64'h8000_0004);
        push("rst_jal",     1, 64'h8000_0010, I_JAL_P16, 1, 1, 64'h8000_0020);
        push("rst_jalr",    1, 64'h8000_0000, I_JALR,    1, 0, 64'h8000_0004);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clock);
            io_valid = it.valid; io_pc = it.pc; io_inst = it.inst;
            #1;
            total++;
            if ({io_jump, io_pred_taken, io_pred_target} !== {it.jump, it.taken, it.target}) begin
                bad++;
                $display("FAIL %s: got jump=%0b taken=%0b target=%h, want jump=%0b taken=%0b target=%h",
                         it.name, io_jump, io_pred_taken, io_pred_target, it.jump, it.taken, it.target);
            end
        end
        @(negedge clock);
        reset = 1'b1;
        push("post_rst_beq",  1, 64'h8000_0000, I_BEQ_P8,  1, 0, 64'h8000_0004);
        push("post_rst_jalr", 1, 64'h8000_0000, I_JALR,    1, 0, 64'h8000_0004);
        push("invalid_jal",   0, 64'h8000_0010, I_JAL_P16, 1, 0, 64'h8000_0014);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clock);
            io_valid = it.valid; io_pc = it.pc; io_inst = it.inst;
            #1;
            total++;
            if ({io_jump, io_pred_taken, io_pred_target} !== {it.jump, it.taken, it.target}) begin
                bad++;
                $display("FAIL %s: got jump=%0b taken=%0b target=%h, want jump=%0b taken=%0b target=%h",
                         it.name, io_jump, io_pred_taken, io_pred_target, it.jump, it.taken, it.target);
            end
        end
    endtask

    task automatic test_predecode();
        item_t it;
        push("bne",        1, 64'h100, 32'h0000_1463, 1, 0, 64'h104);
        push("br_f3_2",    1, 64'h100, 32'h0000_2463, 0, 0, 64'h104);
        push("br_f3_3",    1, 64'h100, 32'h0000_3463, 0, 0, 64'h104);
        push("bltu",       1, 64'h100, 32'h0000_6463, 1, 0, 64'h104);
        push("jalr_f3_1",  1, 64'h100, 32'h0000_9067, 0, 0, 64'h104);
        push("ecall",      1, 64'h100, 32'h0000_0073, 1, 0, 64'h104);
        push("ebreak",     1, 64'h100, 32'h0010_0073, 1, 0, 64'h104);
        push("mret",       1, 64'h100, I_MRET,        1, 0, 64'h104);
        push("wfi",        1, 64'h100, 32'h1050_0073, 0, 0, 64'h104);
        push("addi",       1, 64'h100, I_ADDI,        0, 0, 64'h104);
        push("wrap_plus4", 1, 64'hffff_ffff_ffff_fffc, I_ADDI, 0, 0, 64'h0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clock);
            io_valid = it.valid; io_pc = it.pc; io_inst = it.inst;
            #1;
            total++;
            if ({io_jump, io_pred_taken, io_pred_target} !== {it.jump, it.taken, it.target}) begin
                bad++;
                $display("FAIL %s: got jump=%0b taken=%0b target=%h, want jump=%0b taken=%0b target=%h",
                         it.name, io_jump, io_pred_taken, io_pred_target, it.jump, it.taken, it.target);
            end
        end
    endtask

    task automatic test_jal();
        item_t it;
        push("jal_p16",  1, 64'h8000_0010, I_JAL_P16, 1, 1, 64'h8000_0020);
        push("jal_m4",   1, 64'h8000_0010, I_JAL_M4,  1, 1, 64'h8000_000c);
        push("jal_wrap", 1, 64'hffff_ffff_ffff_fff0, I_JAL_P16, 1, 1, 64'h0);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clock);
            io_valid = it.valid; io_pc = it.pc; io_inst = it.inst;
            #1;
            total++;
            if ({io_jump, io_pred_taken, io_pred_target} !== {it.jump, it.taken, it.target}) begin
                bad++;
                $display("FAIL %s: got jump=%0b taken=%0b target=%h, want jump=%0b taken=%0b target=%h",
                         it.name, io_jump, io_pred_taken, io_pred_target, it.jump, it.taken, it.target);
            end
        end
    endtask

    task automatic test_counter();
        item_t it;
        // one taken update allocates weakly-taken
        do_update(64'h8000_0000, 1, 64'h1234);
        push("alloc_wt_beq", 1, 64'h8000_0000, I_BEQ_P8, 1, 1, 64'h8000_0008);
        for (int unsigned step = 0; step < 8; step++) begin
            case (step)
                0: ;
                1: begin
                    do_update(64'h8000_0000, 1, 64'h1234);
                    push("st_beq_p8",  1, 64'h8000_0000, I_BEQ_P8,  1, 1, 64'h8000_0008);
                    push("st_beq_m8",  1, 64'h8000_0000, I_BEQ_M8,  1, 1, 64'h7fff_fff8);
                    push("st_jalr",    1, 64'h8000_0000, I_JALR,    1, 1, 64'h1234);
                    push("st_jal",     1, 64'h8000_0000, I_JAL_P16, 1, 1, 64'h8000_0010);
                end
                2: begin
                    do_update(64'h8000_0000, 0, 64'hdead);
                    push("nt1_jalr_keep", 1, 64'h8000_0000, I_JALR, 1, 1, 64'h1234);
                end
                3: begin
                    do_update(64'h8000_0000, 0, 64'hdead);
                    push("nt2_beq", 1, 64'h8000_0000, I_BEQ_P8, 1, 0, 64'h8000_0004);
                end
                4: begin
                    do_update(64'h8000_0000, 0, 64'hdead);
                    push("nt3_beq", 1, 64'h8000_0000, I_BEQ_P8, 1, 0, 64'h8000_0004);
                end
                5: do_update(64'h8000_0000, 0, 64'hdead);
                6: begin
                    do_update(64'h8000_0000, 1, 64'h5550);
                    push("sat_low_jalr", 1, 64'h8000_0000, I_JALR, 1, 0, 64'h8000_0004);
                end
                default: begin
                    do_update(64'h8000_0000, 1, 64'h6660);
                    push("retrain_jalr", 1, 64'h8000_0000, I_JALR, 1, 1, 64'h6660);
                end
            endcase
            while (sb.size() != 0) begin
                it = sb.pop_front();
                @(negedge clock);
                io_valid = it.valid; io_pc = it.pc; io_inst = it.inst;
                #1;
                total++;
                if ({io_jump, io_pred_taken, io_pred_target} !== {it.jump, it.taken, it.target}) begin
                    bad++;
                    $display("FAIL %s: got jump=%0b taken=%0b target=%h, want jump=%0b taken=%0b target=%h",
                             it.name, io_jump, io_pred_taken, io_pred_target, it.jump, it.taken, it.target);
                end
            end
        end
    endtask

    task automatic test_bypass();
        item_t it;
        push("same_cycle_old", 1, 64'h8000_0000, I_BEQ_P8, 1, 1, 64'h8000_0008);
        push("next_cycle_new", 1, 64'h8000_0000, I_BEQ_P8, 1, 0, 64'h8000_0004);
        @(negedge clock);
        io_upd_valid = 1'b1; io_upd_pc = 64'h8000_0000; io_upd_taken = 1'b0; io_upd_target = '0;
        it = sb.pop_front();
        io_valid = it.valid; io_pc = it.pc; io_inst = it.inst;
        #1;
        total++;
        if ({io_jump, io_pred_taken, io_pred_target} !== {it.jump, it.taken, it.target}) begin
            bad++;
            $display("FAIL %s: got jump=%0b taken=%0b target=%h, want jump=%0b taken=%0b target=%h",
                     it.name, io_jump, io_pred_taken, io_pred_target, it.jump, it.taken, it.target);
        end
        push("alias_beq",  1, 64'h8000_0040, I_BEQ_P8, 1, 0, 64'h8000_0044);
        push("alias_jalr", 1, 64'h8000_0040, I_JALR,   1, 0, 64'h8000_0044);
        @(negedge clock);
        io_upd_valid = 1'b0;
        while (sb.size() != 0) begin
            it = sb.pop_front();
            io_valid = it.valid; io_pc = it.pc; io_inst = it.inst;
            #1;
            total++;
            if ({io_jump, io_pred_taken, io_pred_target} !== {it.jump, it.taken, it.target}) begin
                bad++;
                $display("FAIL %s: got jump=%0b taken=%0b target=%h, want jump=%0b taken=%0b target=%h",
                         it.name, io_jump, io_pred_taken, io_pred_target, it.jump, it.taken, it.target);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_flush();
        item_t it;
        do_update(64'h8000_0000, 1, 64'h1000);
        do_update(64'h8000_0004, 1, 64'h7770);
        push("pre_flush_jalr", 1, 64'h8000_0004, I_JALR,   1, 1, 64'h7770);
        push("pre_flush_beq",  1, 64'h8000_0000, I_BEQ_P8, 1, 1, 64'h8000_0008);
        for (int unsigned phase = 0; phase < 3; phase++) begin
            if (phase == 1) begin
                @(negedge clock);
                io_flush = 1'b1;
                io_upd_valid = 1'b1; io_upd_pc = 64'h8000_0008; io_upd_taken = 1'b1;
                io_upd_target = 64'h8880;
                @(negedge clock);
                io_flush = 1'b0; io_upd_valid = 1'b0;
                push("flush_beq0",   1, 64'h8000_0000, I_BEQ_P8, 1, 0, 64'h8000_0004);
                push("flush_jalr4",  1, 64'h8000_0004, I_JALR,   1, 0, 64'h8000_0008);
                push("flush_no_alloc", 1, 64'h8000_0008, I_JALR, 1, 0, 64'h8000_000c);
                push("mret",         1, 64'h8000_0000, I_MRET,   1, 0, 64'h8000_0004);
            end else if (phase == 2) begin
                do_update(64'h8000_0000, 1, 64'h2220);
                push("realloc_jalr", 1, 64'h8000_0000, I_JALR, 1, 1, 64'h2220);
            end
            while (sb.size() != 0) begin
                it = sb.pop_front();
                @(negedge clock);
                io_valid = it.valid; io_pc = it.pc; io_inst = it.inst;
                #1;
                total++;
                if ({io_jump, io_pred_taken, io_pred_target} !== {it.jump, it.taken, it.target}) begin
                    bad++;
                    $display("FAIL %s: got jump=%0b taken=%0b target=%h, want jump=%0b taken=%0b target=%h",
                             it.name, io_jump, io_pred_taken, io_pred_target, it.jump, it.taken, it.target);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        item_t it;
        push("pre_areset",  1, 64'h8000_0000, I_BEQ_P8, 1, 1, 64'h8000_0008);
        push("in_areset",   1, 64'h8000_0000, I_BEQ_P8, 1, 0, 64'h8000_0004);
        push("addi_areset", 1, 64'h8000_0000, I_ADDI,   0, 0, 64'h8000_0004);
        @(negedge clock);
        for (int unsigned k = 0; k < 3; k++) begin
            if (k == 1) reset = 1'b0;
            it = sb.pop_front();
            io_valid = it.valid; io_pc = it.pc; io_inst = it.inst;
            #1;
            total++;
            if ({io_jump, io_pred_taken, io_pred_target} !== {it.jump, it.taken, it.target}) begin
                bad++;
                $display("FAIL %s: got jump=%0b taken=%0b target=%h, want jump=%0b taken=%0b target=%h",
                         it.name, io_jump, io_pred_taken, io_pred_target, it.jump, it.taken, it.target);
            end
        end
        @(negedge clock);
        reset = 1'b1;
        // reset lands while an update is being presented
        @(negedge clock);
        io_upd_valid = 1'b1; io_upd_pc = 64'h8000_0020; io_upd_taken = 1'b1; io_upd_target = 64'h4440;
        #2 reset = 1'b0;
        @(negedge clock);
        io_upd_valid = 1'b0;
        #1 reset = 1'b1;
        push("mid_upd_beq",  1, 64'h8000_0020, I_BEQ_P8, 1, 0, 64'h8000_0024);
        push("mid_upd_jalr", 1, 64'h8000_0020, I_JALR,   1, 0, 64'h8000_0024);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clock);
            io_valid = it.valid; io_pc = it.pc; io_inst = it.inst;
            #1;
            total++;
            if ({io_jump, io_pred_taken, io_pred_target} !== {it.jump, it.taken, it.target}) begin
                bad++;
                $display("FAIL %s: got jump=%0b taken=%0b target=%h, want jump=%0b taken=%0b target=%h",
                         it.name, io_jump, io_pred_taken, io_pred_target, it.jump, it.taken, it.target);
            end
        end
    endtask

    task automatic test_back_to_back();
        item_t it;
        logic [63:0] pc;
        logic [63:0] tgt;
        for (int unsigned k = 0; k < 8; k++) begin
            pc  = 64'h8000_0100 + 64'(4 * k);
            tgt = 64'h9000_0000 + 64'(k * 32'h40);
            @(negedge clock);
            io_upd_valid = 1'b1; io_upd_pc = pc; io_upd_taken = 1'b1; io_upd_target = tgt;
            push($sformatf("b2b_jalr%0d", k), 1, pc, I_JALR, 1, 1, tgt);
        end
        @(negedge clock);
        io_upd_valid = 1'b0;
        push("b2b_alias", 1, 64'h8000_0008, I_JALR, 1, 0, 64'h8000_000c);
        while (sb.size() != 0) begin
            it = sb.pop_front();
            @(negedge clock);
            io_valid = it.valid; io_pc = it.pc; io_inst = it.inst;
            #1;
            total++;
            if ({io_jump, io_pred_taken, io_pred_target} !== {it.jump, it.taken, it.target}) begin
                bad++;
                $display("FAIL %s: got jump=%0b taken=%0b target=%h, want jump=%0b taken=%0b target=%h",
                         it.name, io_jump, io_pred_taken, io_pred_target, it.jump, it.taken, it.target);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_predecode();
        test_jal();
        test_counter();
        test_bypass();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_bpu.md
IFU_BPU -- requirements
Module: ifu_bpu

Interface
REQ-001 Parameter XLEN, default 64, address/data width of pc and targets.
REQ-002 Parameter ENTRIES, default 16, table depth; power of two, >=2; IDX_W = log2(ENTRIES).
REQ-003 Parameter TAG_W, default 8, stored tag width.
REQ-004 clock  input  1  single clock, all state rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 io_valid  input  1  fetch slot holds a valid instruction.
REQ-007 io_pc  input  XLEN  pc of fetched instruction.
REQ-008 io_inst  input  32  fetched instruction.
REQ-009 io_jump  output  1  instruction is control-flow (pre-decode flag).
REQ-010 io_pred_taken  output  1  predicted redirect.
REQ-011 io_pred_target  output  XLEN  predicted next pc.
REQ-012 io_upd_valid / io_upd_pc[XLEN] / io_upd_taken[1] / io_upd_target[XLEN]  input  resolved-branch update from EXU.
REQ-013 io_flush  input  1  invalidate whole table.

Function
REQ-014 io_jump SHALL be 1 for: opcode 0x6f; opcode 0x67 with funct3=0; opcode 0x63 with funct3 in {0,1,4,5,6,7}; inst == 0x00000073, 0x30200073 or 0x00100073; else 0; purely combinational from io_inst, independent of io_valid and reset.
REQ-015 Lookup index = io_pc[IDX_W+1:2]; tag = io_pc[IDX_W+TAG_W+1:IDX_W+2]; hit = entry valid and tag equal; lookup is combinational from table registers (0-cycle latency).
REQ-016 Each entry SHALL hold valid, TAG_W tag, 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST), XLEN target.
REQ-017 JAL: pred_taken=1, target = pc + sign-extended J-immediate, table ignored.
REQ-018 Conditional branch: pred_taken = hit & counter[1]; target = pc + sign-extended B-immediate when taken.
REQ-019 JALR: pred_taken = hit & counter[1]; target = stored entry target.
REQ-020 ECALL/MRET/EBREAK and non-control-flow: pred_taken=0.
REQ-021 Whenever pred_taken=0, io_pred_target SHALL equal io_pc+4; all pc arithmetic modulo 2^XLEN (wrap, no overflow flag).
REQ-022 io_valid=0 forces io_pred_taken=0, target=io_pc+4.
REQ-023 Update on io_upd_valid, at upd index/tag: miss -> allocate valid=1, tag, counter = taken?10:01, target=io_upd_target; hit -> counter +1 if taken (saturate 11), -1 if not (saturate 00), target overwritten only if taken.
REQ-024 Update takes effect next cycle; same-cycle lookup of the updated index returns the pre-update value (no bypass).
REQ-025 io_flush clears all valid bits in one cycle; counters/targets untouched; flush with simultaneous update: flush wins, update dropped.

Reset
REQ-026 Reset assertion SHALL asynchronously clear all valid bits, set all counters to 01, targets to 0.
REQ-027 During and after reset until first update, io_pred_taken SHALL be 0 for all non-JAL instructions; reset mid-update discards the update.

Structure
REQ-028 Shared package SHALL hold opcode constants (0x63, 0x67, 0x6f, 0x73), ECALL/MRET/EBREAK encodings, branch funct3 set, counter encodings, and the instruction-class enum.
REQ-029 One sub-module, ifu_predecode: combinational class decode, io_jump, and B/J immediate extraction; table and update logic stay in ifu_bpu.

Verification
REQ-030 After reset, pc=0x80000000, inst=0x00000463 (beq +8) -> jump=1, pred_taken=0, target=0x80000004.
REQ-031 pc=0x80000010, inst=0x0100006f (jal +16) -> pred_taken=1, target=0x80000020, regardless of table state.
REQ-032 Two taken updates for pc=0x80000000, then lookup of beq +8 -> pred_taken=1, target=0x80000008; three not-taken updates -> counter 00, pred_taken=0.
REQ-033 Update for pc 0x80000000 and lookup same cycle -> old prediction; next cycle -> new; alias pc 0x80000040 (ENTRIES=16, same index, different tag) -> miss, pred_taken=0.
REQ-034 Populated table, io_flush=1 with io_upd_valid=1 -> all lookups miss next cycle, no entry allocated; inst 0x30200073 -> jump=1, pred_taken=0.
REQ-035 Reset pulsed low mid-run asynchronously (between edges) -> table invalid immediately; inst 0x00000013 -> jump=0, pred_taken=0.
